// File: rtl/text_pkg.sv
// text_pkg: shared screen constants, colour codes, cell word layout and 8x8 font.
// Latency: none (declarations plus a combinational font lookup).
// Backpressure: none.
package text_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int GLYPH_W  = 8;
   localparam int GLYPH_H  = 8;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] WHITE = 3'b111;

   // Cell word: [7:0] character code, [10:8] foreground colour.
   localparam int CHAR_LSB = 0;
   localparam int CHAR_MSB = 7;
   localparam int FG_LSB   = 8;
   localparam int FG_MSB   = 10;
   localparam int CELL_W   = FG_MSB + 1;

   typedef struct packed {
      logic [FG_MSB-FG_LSB:0]     fg;
      logic [CHAR_MSB-CHAR_LSB:0] chr;
   } cell_t;

   // Font bitmap: 8 rows of 8 bits, row 0 in the top byte, leftmost pixel in
   // the MSB of each row. Unknown codes render as a hollow box so that they
   // remain visible on screen.
   function automatic logic [GLYPH_W-1:0] font_row(input logic [7:0] chr,
                                                    input logic [2:0] gy);
      logic [GLYPH_W*GLYPH_H-1:0] bmp;
      logic [GLYPH_W*GLYPH_H-1:0] sh;
      case (chr)
         8'h20:   bmp = 64'h0000_0000_0000_0000;
         8'h41:   bmp = 64'h183C_6666_7E66_6600;
         8'h42:   bmp = 64'h7C66_667C_6666_7C00;
         default: bmp = 64'hFF81_8181_8181_81FF;
      endcase
      sh = bmp << {gy, 3'b000};
      return sh[GLYPH_W*GLYPH_H-1 -: GLYPH_W];
   endfunction

endpackage

// File: rtl/text_cell_ram.sv
// text_cell_ram: simple dual-port character cell store, DEPTH x 11 bits.
// Latency: 1 clk registered read; a same-cycle write to the read address returns old data.
// Backpressure: none; writes at or beyond DEPTH are dropped.
// Ports: clk; we/waddr/wdata write port; raddr/rdata registered read port.
module text_cell_ram
   import text_pkg::*;
#(
   parameter int DEPTH  = 2400,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  cell_t             wdata,
   input  logic [ADDR_W-1:0] raddr,
   output cell_t             rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   cell_t mem [DEPTH];

   logic wr_ok;
   assign wr_ok = we && ({1'b0, waddr} < (ADDR_W+1)'(DEPTH));

   // Read and write share one block so a colliding read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[IDX_W'(waddr)] <= wdata;
      end
      rdata <= mem[IDX_W'(raddr)];
   end

endmodule

// File: rtl/text_renderer.sv
// text_renderer: text-mode pixel generator with zoom, blinking underline cursor and red border.
// Latency: 3 clk from x_px/y_px/hsync_in/vsync_in/active_in to rgb/hsync/vsync.
// Backpressure: none; free-running at the pixel clock, cell writes always accepted.
// Ports: clk/rst; vga_sync timing in (x_px, y_px, hsync_in, vsync_in, active_in);
//        host cell write (we, waddr, wdata); cursor_en/cursor_addr; hsync, vsync, rgb out.
module text_renderer
   import text_pkg::*;
#(
   parameter int COLS         = 80,
   parameter int ROWS         = 30,
   parameter int ZOOM         = 0,
   parameter int BLINK_FRAMES = 32,
   parameter int ADDR_W       = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        x_px,
   input  logic [9:0]        y_px,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              active_in,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [10:0]       wdata,
   input  logic              cursor_en,
   input  logic [ADDR_W-1:0] cursor_addr,
   output logic              hsync,
   output logic              vsync,
   output logic [2:0]        rgb
);

   localparam int SH   = 3 + ZOOM;
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   // ---------------- S0: cell coordinates and address ----------------
   logic [9:0]        col_full, row_full;
   logic [6:0]        col;
   logic [5:0]        row;
   logic [ADDR_W-1:0] s0_addr, s0_raddr;
   logic [2:0]        s0_gx, s0_gy;
   logic              s0_in_text, s0_border, s0_cur;
   logic              blink_on;

   always_comb begin
      col_full   = x_px >> SH;
      row_full   = y_px >> SH;
      col        = 7'(col_full);
      row        = 6'(row_full);
      s0_in_text = (col_full < 10'(COLS)) && (row_full < 10'(ROWS));
      s0_addr    = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
      // Off-grid pixels read cell 0; the result is discarded by in_text anyway.
      s0_raddr   = s0_in_text ? s0_addr : '0;
      s0_gx      = 3'(x_px >> ZOOM);
      s0_gy      = 3'(y_px >> ZOOM);
      s0_border  = (x_px == 10'd0) || (x_px == 10'(H_ACTIVE-1)) ||
                   (y_px == 10'd0) || (y_px == 10'(V_ACTIVE-1));
      s0_cur     = cursor_en && blink_on && s0_in_text &&
                   (s0_gy == 3'd7) && (s0_addr == cursor_addr);
   end

   // ---------------- S1: cell RAM read ----------------
   cell_t cell_rd;

   text_cell_ram #(
      .DEPTH  (COLS*ROWS),
      .ADDR_W (ADDR_W)
   ) u_cell_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (cell_t'(wdata)),
      .raddr (s0_raddr),
      .rdata (cell_rd)
   );

   logic             s1_act, s1_in_text, s1_border, s1_cur, s1_hs, s1_vs;
   logic [2:0]       s1_gx, s1_gy;

   // ---------------- S2: glyph ROM read ----------------
   logic             s2_act, s2_in_text, s2_border, s2_cur, s2_hs, s2_vs;
   logic [2:0]       s2_gx, s2_fg;
   logic [GLYPH_W-1:0] s2_glyph;

   // ---------------- Blink timebase ----------------
   logic             vs_q;
   logic [FC_W-1:0]  frame_cnt;

   // ---------------- S3: pixel colour ----------------
   logic [2:0] pix;

   always_comb begin
      pix = BLACK;
      if (s2_act) begin
         if (s2_in_text) begin
            // Cursor underline takes the cell colour, but must stay visible on fg=000.
            if (s2_cur) begin
               pix = (s2_fg == BLACK) ? WHITE : s2_fg;
            end else if (s2_glyph[3'd7 - s2_gx]) begin
               pix = s2_fg;
            end
         end else if (s2_border) begin
            pix = RED;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_act     <= 1'b0;
         s1_in_text <= 1'b0;
         s1_border  <= 1'b0;
         s1_cur     <= 1'b0;
         s1_hs      <= 1'b0;
         s1_vs      <= 1'b0;
         s1_gx      <= '0;
         s1_gy      <= '0;
         s2_act     <= 1'b0;
         s2_in_text <= 1'b0;
         s2_border  <= 1'b0;
         s2_cur     <= 1'b0;
         s2_hs      <= 1'b0;
         s2_vs      <= 1'b0;
         s2_gx      <= '0;
         s2_fg      <= '0;
         s2_glyph   <= '0;
         rgb        <= BLACK;
         hsync      <= 1'b0;
         vsync      <= 1'b0;
         vs_q       <= 1'b0;
         frame_cnt  <= '0;
         blink_on   <= 1'b1;
      end else begin
         s1_act     <= active_in;
         s1_in_text <= s0_in_text;
         s1_border  <= s0_border;
         s1_cur     <= s0_cur;
         s1_hs      <= hsync_in;
         s1_vs      <= vsync_in;
         s1_gx      <= s0_gx;
         s1_gy      <= s0_gy;

         s2_act     <= s1_act;
         s2_in_text <= s1_in_text;
         s2_border  <= s1_border;
         s2_cur     <= s1_cur;
         s2_hs      <= s1_hs;
         s2_vs      <= s1_vs;
         s2_gx      <= s1_gx;
         s2_fg      <= cell_rd.fg;
         s2_glyph   <= font_row(cell_rd.chr, s1_gy);

         rgb        <= pix;
         hsync      <= s2_hs;
         vsync      <= s2_vs;

         // One frame per rising edge of the raw vsync.
         vs_q <= vsync_in;
         if (vsync_in && !vs_q) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES-1)) begin
               frame_cnt <= '0;
               blink_on  <= !blink_on;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule
